hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline control unit for the 5-stage RV32 core; generates the front-end controls consumed by the fetch stage and IF/ID register: PCWrite, if_id_write and PCSrc.
- Also generates flush/bubble controls for IF/ID and ID/EX, plus halt and data-memory-wait sequencing.
- Sits between ID/EX, EX and data memory, and the PC/IF/ID logic.
- Maintains saturating performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_WIDTH, 16, width of each saturating performance counter.
- MAX_WAIT, 64, consecutive dmem_busy cycles after which mem_timeout sets.
- WAIT_W, 8, width of the internal wait counter (must hold MAX_WAIT).

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifid_rs1  in  5  rs1 field of the instruction in IF/ID.
- ifid_rs2  in  5  rs2 field of the instruction in IF/ID.
- ifid_uses_rs1  in  1  ID instruction reads rs1.
- ifid_uses_rs2  in  1  ID instruction reads rs2.
- ifid_halt_req  in  1  ID instruction is ebreak/ecall.
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rd  in  5  destination register of ID/EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- dmem_busy  in  1  data memory not ready; freeze pipeline.
- resume  in  1  single-cycle pulse to leave HALT.
- PCWrite  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- PCSrc  out  1  1 selects branch target.
- if_id_flush  out  1  zero IF/ID on next edge.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  load NOP into ID/EX.
- halted  out  1  FSM in HALT.
- mem_timeout  out  1  sticky wait-limit flag.
- stall_cycles  out  CNT_WIDTH  load-use plus halt stall cycles.
- flush_count  out  CNT_WIDTH  taken-branch flushes.
- mem_wait_cycles  out  CNT_WIDTH  dmem_busy cycles.

Behaviour:
- Reset (reset=0, async):
  - State=RUN; wait counter, all perf counters, halted and mem_timeout = 0.
  - While reset is low, combinational outputs are forced to PCWrite=0, if_id_write=0, id_ex_write=0, PCSrc=0, if_id_flush=0, id_ex_bubble=0.
  - Reset mid-operation aborts any state immediately.
- FSM states: RUN, MEM_WAIT, HALT. Control outputs are combinational from state and inputs; state and counters are registered.
- Defaults (no hazard): PCWrite=1, if_id_write=1, id_ex_write=1, all others 0.
- load_use = idex_mem_read & (idex_rd!=0) & ((ifid_uses_rs1 & ifid_rs1==idex_rd) | (ifid_uses_rs2 & ifid_rs2==idex_rd)).
- Priority within one cycle, in any state: dmem_busy > ex_branch_taken > HALT hold > load_use > ifid_halt_req.
- dmem_busy=1:
  - Full freeze: PCWrite=0, if_id_write=0, id_ex_write=0; no flush, no bubble.
  - Next state MEM_WAIT; mem_wait_cycles+1; wait counter+1.
  - A branch held in EX is serviced on the first non-busy cycle.
- MEM_WAIT:
  - When the wait counter reaches MAX_WAIT with busy still high, mem_timeout sets and stays set until reset.
  - busy=0: wait counter clears; return to RUN, or to HALT if halted was latched before the wait; evaluate the remaining priorities that same cycle.
- ex_branch_taken (not busy):
  - PCSrc=1, PCWrite=1, if_id_flush=1, id_ex_bubble=1; flush_count+1.
  - Overrides load_use and ifid_halt_req, because the ID instruction is squashed.
  - In HALT, a branch cannot arrive: EX holds a bubble.
- load_use (RUN, not busy, no branch):
  - PCWrite=0, if_id_write=0, id_ex_bubble=1; stall_cycles+1.
  - Lasts exactly one cycle because the load advances.
- ifid_halt_req (RUN, no higher condition):
  - The halt instruction advances normally this cycle.
  - Next state HALT; halted=1 from the next cycle.
- HALT:
  - PCWrite=0, if_id_write=0, id_ex_bubble=1 each cycle; stall_cycles+1 per cycle.
  - resume=1: return to RUN and drop the hold in that same cycle; halted=0 next cycle. resume in RUN is ignored.
- Counters saturate at all-ones and never wrap.
- Simultaneous busy and halt: busy freezes first; halt is taken once busy drops.

Test Plan:
- Reset release, then 5 idle cycles → PCWrite=1, if_id_write=1, id_ex_write=1, all counters 0, halted=0.
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs1=5, uses_rs1=1 for 1 cycle → PCWrite=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cycles=1. Same stimulus with idex_rd=0 → no stall.
- Load-use and ex_branch_taken in the same cycle → PCSrc=1, if_id_flush=1, id_ex_bubble=1, PCWrite=1; flush_count=1, stall_cycles=0.
- dmem_busy high for 3 cycles while ex_branch_taken=1:
  - During busy: all writes 0, PCSrc=0, mem_wait_cycles=3.
  - Cycle after busy drops: PCSrc=1, flush_count=1.
- MAX_WAIT=4, busy held 6 cycles → mem_timeout=1 after the 4th busy cycle and stays 1 after busy drops; cleared only by reset.
- ifid_halt_req pulse → halted=1 next cycle; hold for 10 cycles → stall_cycles=10; resume pulse → PCWrite=1 that cycle, halted=0 next. Then assert reset during HALT → immediate RUN, counters 0.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Hazard controller signal bundle: pipeline-side hazard inputs and the
// front-end / ID-EX control outputs plus status counters.
interface hazard_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ifid_rs1_unused_guard; // keeps bundle non-empty if trimmed
    logic [4:0]           ifid_rs1;
    logic [4:0]           ifid_rs2;
    logic                 ifid_uses_rs1;
    logic                 ifid_uses_rs2;
    logic                 ifid_halt_req;
    logic                 idex_mem_read;
    logic [4:0]           idex_rd;
    logic                 ex_branch_taken;
    logic                 dmem_busy;
    logic                 resume;

    logic                 PCWrite;
    logic                 if_id_write;
    logic                 PCSrc;
    logic                 if_id_flush;
    logic                 id_ex_write;
    logic                 id_ex_bubble;
    logic                 halted;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;
    logic [CNT_WIDTH-1:0] mem_wait_cycles;

    // Pipeline side: presents hazard information, consumes controls.
    modport master (
        output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, ifid_halt_req,
               idex_mem_read, idex_rd, ex_branch_taken, dmem_busy, resume,
        input  PCWrite, if_id_write, PCSrc, if_id_flush, id_ex_write, id_ex_bubble,
               halted, mem_timeout, stall_cycles, flush_count, mem_wait_cycles
    );

    // Controller side.
    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, ifid_halt_req,
               idex_mem_read, idex_rd, ex_branch_taken, dmem_busy, resume,
        output PCWrite, if_id_write, PCSrc, if_id_flush, id_ex_write, id_ex_bubble,
               halted, mem_timeout, stall_cycles, flush_count, mem_wait_cycles
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage RV32 core: load-use stalls,
// taken-branch flushes, data-memory wait freeze, halt/resume sequencing,
// saturating performance counters and a sticky memory-timeout flag.
module hazard_controller #(
    parameter int CNT_WIDTH = 16,
    parameter int MAX_WAIT  = 64,
    parameter int WAIT_W    = 8
) (
    input  logic               clock,
    input  logic               reset,   // active-low, asynchronous
    hazard_controller_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  halted_q, halted_d;
    logic                  tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic [CNT_WIDTH-1:0]  flush_q, flush_d;
    logic [CNT_WIDTH-1:0]  mw_q, mw_d;

    logic load_use, hold;
    logic pcw, ifw, pcsrc, flu, idw, bub;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Load-use hazard: ID reads the register a load in ID/EX is about to write.
    always_comb begin
        load_use = bus.idex_mem_read && (bus.idex_rd != 5'd0) &&
                   ((bus.ifid_uses_rs1 && (bus.ifid_rs1 == bus.idex_rd)) ||
                    (bus.ifid_uses_rs2 && (bus.ifid_rs2 == bus.idex_rd)));
    end

    // Next-state, counters and control outputs, in priority order:
    // busy > branch > halt hold > load-use > halt request.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        halted_d = halted_q;
        tmo_d    = tmo_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        mw_d     = mw_q;
        pcw      = 1'b1;
        ifw      = 1'b1;
        idw      = 1'b1;
        pcsrc    = 1'b0;
        flu      = 1'b0;
        bub      = 1'b0;

        // A wait that began in HALT returns to HALT, so the hold follows the latch.
        unique case (state_q)
            HALT:     hold = 1'b1;
            MEM_WAIT: hold = halted_q;
            default:  hold = 1'b0;
        endcase

        if (bus.dmem_busy) begin
            // Full freeze; whatever sits in EX/ID is serviced after busy drops.
            pcw     = 1'b0;
            ifw     = 1'b0;
            idw     = 1'b0;
            state_d = MEM_WAIT;
            mw_d    = sat_inc(mw_q);
            wait_d  = (wait_q == MAX_W) ? wait_q : wait_q + 1'b1;
            if (wait_d == MAX_W) tmo_d = 1'b1;
        end else begin
            wait_d = '0;
            // resume drops the hold in the same cycle it is seen
            if (hold && bus.resume) begin
                hold     = 1'b0;
                halted_d = 1'b0;
            end
            if (bus.ex_branch_taken) begin
                pcsrc   = 1'b1;
                flu     = 1'b1;
                bub     = 1'b1;
                flush_d = sat_inc(flush_q);
            end else if (hold) begin
                pcw     = 1'b0;
                ifw     = 1'b0;
                bub     = 1'b1;
                stall_d = sat_inc(stall_q);
            end else if (load_use) begin
                pcw     = 1'b0;
                ifw     = 1'b0;
                bub     = 1'b1;
                stall_d = sat_inc(stall_q);
            end else if (bus.ifid_halt_req && !halted_q) begin
                // halt instruction advances this cycle; hold starts next cycle
                halted_d = 1'b1;
            end
            state_d = halted_d ? HALT : RUN;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            wait_q   <= '0;
            halted_q <= 1'b0;
            tmo_q    <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
            mw_q     <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
            tmo_q    <= tmo_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            mw_q     <= mw_d;
        end
    end

    // Controls are forced inactive while reset is held low.
    assign bus.PCWrite         = reset & pcw;
    assign bus.if_id_write     = reset & ifw;
    assign bus.id_ex_write     = reset & idw;
    assign bus.PCSrc           = reset & pcsrc;
    assign bus.if_id_flush     = reset & flu;
    assign bus.id_ex_bubble    = reset & bub;
    assign bus.halted          = halted_q;
    assign bus.mem_timeout     = tmo_q;
    assign bus.stall_cycles    = stall_q;
    assign bus.flush_count     = flush_q;
    assign bus.mem_wait_cycles = mw_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller with a scoreboard queue:
// the stimulus process pushes hand-computed expectations, a monitor on the
// falling edge pops and compares the DUT outputs.
module tb_hazard_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hazard_controller_if #(.CNT_WIDTH(4)) hif();

    hazard_controller #(.CNT_WIDTH(4), .MAX_WAIT(4), .WAIT_W(8)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (hif.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1, rs2;
        logic       u1, u2, hreq, mrd;
        logic [4:0] rd;
        logic       br, busy, resume;
    } in_t;

    // {PCWrite, if_id_write, PCSrc, if_id_flush, id_ex_write, id_ex_bubble}
    typedef struct packed {
        logic [5:0] ctl;
        logic       hlt, tmo;
        logic [3:0] st, fc, mw;
    } exp_t;

    localparam logic [5:0] RUNO  = 6'b110010;
    localparam logic [5:0] STALL = 6'b000011;
    localparam logic [5:0] BR    = 6'b111111;
    localparam logic [5:0] ZERO  = 6'b000000;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t E(input logic [5:0] c, input logic h, input logic t,
                               input int s, input int f, input int m);
        exp_t e;
        e.ctl = c; e.hlt = h; e.tmo = t;
        e.st = 4'(s); e.fc = 4'(f); e.mw = 4'(m);
        return e;
    endfunction

    task automatic vec(input in_t i, input exp_t e);
        @(posedge clk); #1;
        rst_n               = i.rst_n;
        hif.ifid_rs1        = i.rs1;
        hif.ifid_rs2        = i.rs2;
        hif.ifid_uses_rs1   = i.u1;
        hif.ifid_uses_rs2   = i.u2;
        hif.ifid_halt_req   = i.hreq;
        hif.idex_mem_read   = i.mrd;
        hif.idex_rd         = i.rd;
        hif.ex_branch_taken = i.br;
        hif.dmem_busy       = i.busy;
        hif.resume          = i.resume;
        sb.push_back(e);
    endtask

    // Monitor: compares whenever an expectation is pending.
    always @(negedge clk) begin : mon
        exp_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {hif.PCWrite, hif.if_id_write, hif.PCSrc, hif.if_id_flush,
                 hif.id_ex_write, hif.id_ex_bubble, hif.halted, hif.mem_timeout,
                 hif.stall_cycles, hif.flush_count, hif.mem_wait_cycles};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d t=%0t: got ctl=%b h=%b t=%b st=%0d fc=%0d mw=%0d, expected ctl=%b h=%b t=%b st=%0d fc=%0d mw=%0d",
                         n_cmp, $time, a.ctl, a.hlt, a.tmo, a.st, a.fc, a.mw,
                         e.ctl, e.hlt, e.tmo, e.st, e.fc, e.mw);
            end
        end
    end

    initial begin
        in_t idle, rst, v;
        idle = '0; idle.rst_n = 1'b1;
        rst  = '0;
        hif.ifid_rs1 = '0; hif.ifid_rs2 = '0; hif.ifid_uses_rs1 = 0; hif.ifid_uses_rs2 = 0;
        hif.ifid_halt_req = 0; hif.idex_mem_read = 0; hif.idex_rd = '0;
        hif.ex_branch_taken = 0; hif.dmem_busy = 0; hif.resume = 0;

        // reset state, then idle
        vec(rst, E(ZERO, 0, 0, 0, 0, 0));
        repeat (5) vec(idle, E(RUNO, 0, 0, 0, 0, 0));

        // load-use on rs1, then rd==x0 (no hazard), then rs2 path
        v = idle; v.mrd = 1; v.rd = 5'd5; v.rs1 = 5'd5; v.u1 = 1;
        vec(v, E(STALL, 0, 0, 0, 0, 0));
        vec(idle, E(RUNO, 0, 0, 1, 0, 0));
        v.rd = 5'd0; v.rs1 = 5'd0;
        vec(v, E(RUNO, 0, 0, 1, 0, 0));
        v = idle; v.mrd = 1; v.rd = 5'd7; v.rs2 = 5'd7; v.u2 = 1;
        vec(v, E(STALL, 0, 0, 1, 0, 0));
        v.u2 = 0;
        vec(v, E(RUNO, 0, 0, 2, 0, 0));
        vec(idle, E(RUNO, 0, 0, 2, 0, 0));

        // load-use and branch together: branch wins
        vec(rst, E(ZERO, 0, 0, 0, 0, 0));
        v = idle; v.mrd = 1; v.rd = 5'd5; v.rs1 = 5'd5; v.u1 = 1; v.br = 1;
        vec(v, E(BR, 0, 0, 0, 0, 0));
        vec(idle, E(RUNO, 0, 0, 0, 1, 0));

        // busy 3 cycles with a branch held in EX
        vec(rst, E(ZERO, 0, 0, 0, 0, 0));
        v = idle; v.br = 1; v.busy = 1;
        for (int k = 0; k < 3; k++) vec(v, E(ZERO, 0, 0, 0, 0, k));
        v.busy = 0;
        vec(v, E(BR, 0, 0, 0, 0, 3));
        vec(idle, E(RUNO, 0, 0, 0, 1, 3));

        // timeout after 4 busy cycles, sticky; counter saturation
        vec(rst, E(ZERO, 0, 0, 0, 0, 0));
        v = idle; v.busy = 1;
        for (int k = 0; k < 6; k++) vec(v, E(ZERO, 0, (k >= 4), 0, 0, k));
        repeat (2) vec(idle, E(RUNO, 0, 1, 0, 0, 6));
        for (int k = 0; k < 12; k++)
            vec(v, E(ZERO, 0, 1, 0, 0, (6 + k > 15) ? 15 : 6 + k));
        vec(idle, E(RUNO, 0, 1, 0, 0, 15));
        vec(rst, E(ZERO, 0, 0, 0, 0, 0));

        // resume in RUN is ignored
        v = idle; v.resume = 1;
        vec(v, E(RUNO, 0, 0, 0, 0, 0));

        // halt, hold 10 cycles, resume
        v = idle; v.hreq = 1;
        vec(v, E(RUNO, 0, 0, 0, 0, 0));
        for (int k = 0; k < 10; k++) vec(idle, E(STALL, 1, 0, k, 0, 0));
        v = idle; v.resume = 1;
        vec(v, E(RUNO, 1, 0, 10, 0, 0));
        vec(idle, E(RUNO, 0, 0, 10, 0, 0));

        // busy together with halt request: freeze first, halt after
        v = idle; v.hreq = 1; v.busy = 1;
        vec(v, E(ZERO, 0, 0, 10, 0, 0));
        v.busy = 0;
        vec(v, E(RUNO, 0, 0, 10, 0, 1));
        vec(idle, E(STALL, 1, 0, 10, 0, 1));
        vec(idle, E(STALL, 1, 0, 11, 0, 1));

        // reset while halted: immediate return, counters cleared
        vec(rst, E(ZERO, 0, 0, 0, 0, 0));
        vec(idle, E(RUNO, 0, 0, 0, 0, 0));

        // drain scoreboard within a bounded number of cycles
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
